// File: rtl/codificador_hamming.sv
// Transmit side of the SECDED link: encodes a 4-bit nibble into an 8-bit
// extended-Hamming codeword, holds it on a parallel port and shifts it out
// LSB first inside a start/stop frame.
module codificador_hamming #(
    parameter int unsigned CICLOS_POR_BIT = 1,
    parameter int unsigned ANCHO_CONTADOR = 8
) (
    input  logic                      reloj,
    input  logic                      reset,
    input  logic [3:0]                dato,
    input  logic                      dato_valido,
    output logic                      listo,
    output logic [7:0]                palabra,
    output logic                      palabra_valida,
    output logic                      tx_serie,
    output logic                      tx_activo,
    output logic [ANCHO_CONTADOR-1:0] cuenta_palabras
);

    localparam int unsigned BAUD_W    = (CICLOS_POR_BIT > 1) ? $clog2(CICLOS_POR_BIT) : 1;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned ULTIMO_BIT = 9;
    localparam int unsigned BIT_PARADA = 9;

    typedef enum logic [0:0] {
        REPOSO = 1'b0,
        ENVIA  = 1'b1
    } estado_t;

    estado_t                   estado_q, estado_d;
    logic                      listo_q, listo_d;
    logic [7:0]                palabra_q, palabra_d;
    logic                      valida_q, valida_d;
    logic                      tx_q, tx_d;
    logic                      activo_q, activo_d;
    logic [ANCHO_CONTADOR-1:0] cuenta_q, cuenta_d;
    logic [7:0]                despl_q, despl_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [BAUD_W-1:0]         baud_q, baud_d;
    logic [7:0]                codigo;

    // Codeword: data on positions 3,5,6,7; Hamming checks on 1,2,4; overall parity on 0.
    function automatic logic [7:0] codifica(input logic [3:0] d);
        logic [7:0] w;
        w    = '0;
        w[3] = d[0];
        w[5] = d[1];
        w[6] = d[2];
        w[7] = d[3];
        w[1] = w[3] ^ w[5] ^ w[7];
        w[2] = w[3] ^ w[6] ^ w[7];
        w[4] = w[5] ^ w[6] ^ w[7];
        w[0] = ^w[7:1];
        return w;
    endfunction

    assign codigo = codifica(dato);

    // State and output registers with synchronous reset.
    always_ff @(posedge reloj) begin
        if (reset) begin
            estado_q <= REPOSO;
            listo_q  <= 1'b1;
            palabra_q <= 8'h00;
            valida_q <= 1'b0;
            tx_q     <= 1'b1;
            activo_q <= 1'b0;
            cuenta_q <= '0;
            despl_q  <= 8'h00;
            idx_q    <= '0;
            baud_q   <= '0;
        end else begin
            estado_q <= estado_d;
            listo_q  <= listo_d;
            palabra_q <= palabra_d;
            valida_q <= valida_d;
            tx_q     <= tx_d;
            activo_q <= activo_d;
            cuenta_q <= cuenta_d;
            despl_q  <= despl_d;
            idx_q    <= idx_d;
            baud_q   <= baud_d;
        end
    end

    // Next-state logic: accept in REPOSO, then walk the 10-bit frame in ENVIA.
    always_comb begin
        estado_d  = estado_q;
        listo_d   = listo_q;
        palabra_d = palabra_q;
        valida_d  = 1'b0;
        tx_d      = tx_q;
        activo_d  = activo_q;
        cuenta_d  = cuenta_q;
        despl_d   = despl_q;
        idx_d     = idx_q;
        baud_d    = baud_q;

        case (estado_q)
            REPOSO: begin
                listo_d  = 1'b1;
                tx_d     = 1'b1;
                activo_d = 1'b0;
                if (dato_valido && listo_q) begin
                    palabra_d = codigo;
                    despl_d   = codigo;
                    valida_d  = 1'b1;
                    cuenta_d  = cuenta_q + ANCHO_CONTADOR'(1);
                    idx_d     = '0;
                    baud_d    = '0;
                    tx_d      = 1'b0;
                    activo_d  = 1'b1;
                    listo_d   = 1'b0;
                    estado_d  = ENVIA;
                end
            end
            ENVIA: begin
                if (baud_q == BAUD_W'(CICLOS_POR_BIT - 1)) begin
                    baud_d = '0;
                    if (idx_q == IDX_W'(ULTIMO_BIT)) begin
                        estado_d = REPOSO;
                        listo_d  = 1'b1;
                        activo_d = 1'b0;
                        tx_d     = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(BIT_PARADA - 1)) begin
                            tx_d = 1'b1;
                        end else begin
                            tx_d    = despl_q[0];
                            despl_d = {1'b0, despl_q[7:1]};
                        end
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    assign listo           = listo_q;
    assign palabra         = palabra_q;
    assign palabra_valida  = valida_q;
    assign tx_serie        = tx_q;
    assign tx_activo       = activo_q;
    assign cuenta_palabras = cuenta_q;

endmodule

// File: tb/tb_codificador_hamming.sv
// Bench for codificador_hamming: three instances (CPB=1, CPB=4, 2-bit counter)
// checked against a positional Hamming model and an explicit frame model.
module tb_codificador_hamming;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Instance 1: CPB=1, 8-bit counter
    logic       rst1, val1, listo1, pv1, tx1, act1;
    logic [3:0] dato1;
    logic [7:0] pal1, cnt1;
    logic [7:0] exp_cnt1;

    // Instance 2: CPB=4
    logic       rst4, val4, listo4, pv4, tx4, act4;
    logic [3:0] dato4;
    logic [7:0] pal4, cnt4;

    // Instance 3: 2-bit counter
    logic       rst2, val2, listo2, pv2, tx2, act2;
    logic [3:0] dato2;
    logic [7:0] pal2;
    logic [1:0] cnt2;

    codificador_hamming #(.CICLOS_POR_BIT(1), .ANCHO_CONTADOR(8)) dut (
        .reloj(clk), .reset(rst1), .dato(dato1), .dato_valido(val1),
        .listo(listo1), .palabra(pal1), .palabra_valida(pv1),
        .tx_serie(tx1), .tx_activo(act1), .cuenta_palabras(cnt1));

    codificador_hamming #(.CICLOS_POR_BIT(4), .ANCHO_CONTADOR(8)) dut4 (
        .reloj(clk), .reset(rst4), .dato(dato4), .dato_valido(val4),
        .listo(listo4), .palabra(pal4), .palabra_valida(pv4),
        .tx_serie(tx4), .tx_activo(act4), .cuenta_palabras(cnt4));

    codificador_hamming #(.CICLOS_POR_BIT(1), .ANCHO_CONTADOR(2)) dut2 (
        .reloj(clk), .reset(rst2), .dato(dato2), .dato_valido(val2),
        .listo(listo2), .palabra(pal2), .palabra_valida(pv2),
        .tx_serie(tx2), .tx_activo(act2), .cuenta_palabras(cnt2));

    // Reference encoder: data fills the non-power-of-two positions 3,5,6,7 in
    // order; check bit p covers every position whose index has bit p set;
    // bit 0 makes the whole word even parity.
    function automatic logic [7:0] model_encode(input logic [3:0] d);
        logic [7:0] w;
        int k;
        w = '0;
        k = 0;
        for (int pos = 3; pos < 8; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                w[pos] = d[k];
                k++;
            end
        end
        for (int p = 1; p < 8; p = p * 2) begin
            logic par;
            par = 1'b0;
            for (int q = 1; q < 8; q++)
                if (q != p && (q & p) != 0) par = par ^ w[q];
            w[p] = par;
        end
        w[0] = ^w[7:1];
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one nibble through instance 1 and checks the whole frame.
    // With hold set, dato_valido stays high with random dato during the frame.
    task automatic send1(input logic [3:0] d, input bit hold);
        logic [7:0] w;
        logic [9:0] f;
        w = model_encode(d);
        f = {1'b1, w, 1'b0};
        dato1 = d;
        val1  = 1'b1;
        step();
        exp_cnt1 = exp_cnt1 + 8'd1;
        if (!hold) val1 = 1'b0;
        vecs++;
        if ({listo1, act1, tx1, pv1} !== 4'b0101) begin
            errs++;
            $display("FAIL accept_flags d=%h got listo/act/tx/pv=%b want 0101", d, {listo1, act1, tx1, pv1});
        end
        vecs++;
        if (pal1 !== w || cnt1 !== exp_cnt1) begin
            errs++;
            $display("FAIL accept_word d=%h got pal=%h cnt=%0d want pal=%h cnt=%0d", d, pal1, cnt1, w, exp_cnt1);
        end
        for (int i = 1; i < 10; i++) begin
            if (hold) dato1 = 4'($urandom);
            step();
            vecs++;
            if ({listo1, act1, tx1, pv1} !== {2'b01, f[i], 1'b0} || pal1 !== w || cnt1 !== exp_cnt1) begin
                errs++;
                $display("FAIL frame_bit%0d d=%h got listo/act/tx/pv=%b pal=%h cnt=%0d want %b pal=%h cnt=%0d",
                         i, d, {listo1, act1, tx1, pv1}, pal1, cnt1, {2'b01, f[i], 1'b0}, w, exp_cnt1);
            end
        end
        step();
        vecs++;
        if ({listo1, act1, tx1, pv1} !== 4'b1010 || pal1 !== w || cnt1 !== exp_cnt1) begin
            errs++;
            $display("FAIL frame_end d=%h got listo/act/tx/pv=%b pal=%h cnt=%0d want 1010 pal=%h cnt=%0d",
                     d, {listo1, act1, tx1, pv1}, pal1, cnt1, w, exp_cnt1);
        end
        val1 = 1'b0;
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst4 = 1'b1; rst2 = 1'b1;
        val1 = 1'b0; val4 = 1'b0; val2 = 1'b0;
        dato1 = '0; dato4 = '0; dato2 = '0;
        step();
        step();
        rst1 = 1'b0; rst4 = 1'b0; rst2 = 1'b0;
        step();
        exp_cnt1 = 8'd0;
        vecs++;
        if ({listo1, act1, tx1, pv1} !== 4'b1010 || pal1 !== 8'h00 || cnt1 !== 8'd0) begin
            errs++;
            $display("FAIL reset_dut1 got listo/act/tx/pv=%b pal=%h cnt=%0d want 1010 pal=00 cnt=0",
                     {listo1, act1, tx1, pv1}, pal1, cnt1);
        end
        vecs++;
        if ({listo4, act4, tx4, pv4} !== 4'b1010 || pal4 !== 8'h00 || cnt4 !== 8'd0) begin
            errs++;
            $display("FAIL reset_dut4 got listo/act/tx/pv=%b pal=%h cnt=%0d want 1010 pal=00 cnt=0",
                     {listo4, act4, tx4, pv4}, pal4, cnt4);
        end
        vecs++;
        if ({listo2, act2, tx2, pv2} !== 4'b1010 || pal2 !== 8'h00 || cnt2 !== 2'd0) begin
            errs++;
            $display("FAIL reset_dut2 got listo/act/tx/pv=%b pal=%h cnt=%0d want 1010 pal=00 cnt=0",
                     {listo2, act2, tx2, pv2}, pal2, cnt2);
        end
    endtask

    // Known codewords plus an exhaustive sweep with decoder-style syndromes.
    task automatic test_encoding();
        logic [3:0] ds [4];
        logic [7:0] ws [4];
        ds = '{4'hB, 4'h0, 4'h1, 4'hF};
        ws = '{8'hAA, 8'h00, 8'h0F, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            send1(ds[i], 1'b0);
            vecs++;
            if (pal1 !== ws[i]) begin
                errs++;
                $display("FAIL known_word d=%h got %h want %h", ds[i], pal1, ws[i]);
            end
        end
        for (int n = 0; n < 16; n++) begin
            logic s1, s2, s3, ov;
            send1(4'(n), 1'b0);
            s1 = pal1[1] ^ pal1[3] ^ pal1[5] ^ pal1[7];
            s2 = pal1[2] ^ pal1[3] ^ pal1[6] ^ pal1[7];
            s3 = pal1[4] ^ pal1[5] ^ pal1[6] ^ pal1[7];
            ov = ^pal1;
            vecs++;
            if ({s3, s2, s1, ov} !== 4'b0000) begin
                errs++;
                $display("FAIL syndrome d=%h word=%h got s3s2s1/par=%b want 0000", 4'(n), pal1, {s3, s2, s1, ov});
            end
        end
    endtask

    task automatic test_hold_valid();
        for (int i = 0; i < 4; i++) send1(4'($urandom), 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) send1(4'($urandom), 1'b0);
    endtask

    // CPB=4: 4 cycles per bit, 40-cycle frame, then reset at cycle 17 of a frame.
    task automatic test_cpb4();
        logic [3:0] d;
        logic [7:0] w;
        logic [9:0] f;
        d = 4'($urandom);
        w = model_encode(d);
        f = {1'b1, w, 1'b0};
        dato4 = d;
        val4  = 1'b1;
        step();
        val4 = 1'b0;
        vecs++;
        if (pal4 !== w || pv4 !== 1'b1 || cnt4 !== 8'd1) begin
            errs++;
            $display("FAIL cpb4_accept got pal=%h pv=%b cnt=%0d want pal=%h pv=1 cnt=1", pal4, pv4, cnt4, w);
        end
        for (int c = 0; c < 40; c++) begin
            if (c > 0) step();
            vecs++;
            if ({listo4, act4, tx4} !== {2'b01, f[c / 4]}) begin
                errs++;
                $display("FAIL cpb4_cycle%0d got listo/act/tx=%b want %b", c, {listo4, act4, tx4}, {2'b01, f[c / 4]});
            end
        end
        step();
        vecs++;
        if ({listo4, act4, tx4} !== 3'b101 || pal4 !== w) begin
            errs++;
            $display("FAIL cpb4_end got listo/act/tx=%b pal=%h want 101 pal=%h", {listo4, act4, tx4}, pal4, w);
        end
        d = 4'($urandom);
        w = model_encode(d);
        f = {1'b1, w, 1'b0};
        dato4 = d;
        val4  = 1'b1;
        step();
        val4 = 1'b0;
        for (int c = 1; c < 17; c++) step();
        vecs++;
        if ({listo4, act4, tx4} !== {2'b01, f[4]} || cnt4 !== 8'd2) begin
            errs++;
            $display("FAIL cpb4_midframe got listo/act/tx=%b cnt=%0d want %b cnt=2", {listo4, act4, tx4}, cnt4, {2'b01, f[4]});
        end
        rst4 = 1'b1;
        step();
        vecs++;
        if ({listo4, act4, tx4, pv4} !== 4'b1010 || pal4 !== 8'h00 || cnt4 !== 8'd0) begin
            errs++;
            $display("FAIL cpb4_abort got listo/act/tx/pv=%b pal=%h cnt=%0d want 1010 pal=00 cnt=0",
                     {listo4, act4, tx4, pv4}, pal4, cnt4);
        end
        rst4 = 1'b0;
        step();
    endtask

    // 2-bit counter: five accepts give 1,2,3,0,1.
    task automatic test_wrap();
        for (int n = 1; n <= 5; n++) begin
            int budget;
            dato2 = 4'($urandom);
            val2  = 1'b1;
            step();
            val2 = 1'b0;
            vecs++;
            if (cnt2 !== 2'(n % 4)) begin
                errs++;
                $display("FAIL wrap_count accept%0d got %0d want %0d", n, cnt2, n % 4);
            end
            budget = 0;
            while (listo2 !== 1'b1 && budget < 50) begin
                step();
                budget++;
            end
            if (budget >= 50) begin
                vecs++;
                errs++;
                $display("FAIL wrap_timeout accept%0d listo=%b want 1 within 50 cycles", n, listo2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_encoding();
        test_hold_valid();
        test_back_to_back();
        test_cpb4();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
